// File: rtl/instr_fetch_queue.sv
// Fetch stage: PC sequencing, 1-cycle imem reads, and an in-order DEPTH-entry queue feeding decode.
// Optional FETCH_PERF_EN adds perf_stall_cnt (cycles with a full queue or nothing for decode).
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [15:0] dec_imm16
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t          q_mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic            inflight_q;
  logic [31:0]     pc_q, inflight_pc_q;
  logic            issue, push, pop;
  entry_t          head;

  // Reserve a slot for every outstanding read so a returning word always has room.
  assign occ     = {1'b0, count} + (CW+1)'(inflight_q);
  assign issue   = rst_n && !redirect && (occ < (CW+1)'(DEPTH));
  assign push    = inflight_q && !redirect;
  assign pop     = dec_valid && dec_ready && !redirect;

  assign imem_en   = issue;
  assign imem_addr = pc_q;

  assign head      = q_mem[rd_ptr];
  assign dec_valid = (count != '0);
  assign dec_instr = dec_valid ? head.instr : 32'h0;
  assign dec_pc    = dec_valid ? head.pc : 32'h0;
  assign dec_imm16 = dec_instr[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
    end else if (redirect) begin
      // Drops queued entries and any returning word; refetch starts next cycle.
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q          <= pc_q + 32'(PC_STEP);
        inflight_pc_q <= pc_q;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset; dec_* are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= '{instr: imem_rdata, pc: inflight_pc_q};
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_stall_cnt <= 32'h0;
    else if ((count == CW'(DEPTH)) || (!dec_valid && !redirect))
      perf_stall_cnt <= perf_stall_cnt + 32'h1;
  end
`endif

endmodule
